// File: rtl/string_cmp_controller.sv
// Word-by-word string compare sequencer: 4-register Avalon-MM slave plus shared read master for buffers A/B.
// Optional: define STRCMP_IRQ_EN to add CONTROL.IE (bit2) and the level interrupt irq = done & IE.
module string_cmp_controller #(
    parameter int MAX_WORDS = 8,
    parameter int ADDR_W    = $clog2(MAX_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [1:0]        address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [31:0]       bufA_rdata,
    input  logic [31:0]       bufB_rdata,
    output logic              irq
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CMP, S_DONE} state_t;

    localparam int         LEN_W        = ADDR_W + 1;
    localparam logic [1:0] REG_CONTROL  = 2'd0;
    localparam logic [1:0] REG_LENGTH   = 2'd1;
    localparam logic [1:0] REG_STATUS   = 2'd2;
    localparam logic [1:0] REG_RESULT   = 2'd3;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] w_q, w_d;
    logic [LEN_W-1:0]  length_q, length_d;
    logic [LEN_W-1:0]  run_len_q, run_len_d;
    logic              done_q, done_d, equal_q, equal_d, lt_q, lt_d;
    logic [15:0]       index_q, index_d, count_q, count_d;
    // Outcome found in CMP, held until DONE publishes it to STATUS/RESULT.
    logic [15:0]       pend_index_q, pend_index_d, pend_count_q, pend_count_d;
    logic              pend_equal_q, pend_equal_d, pend_lt_q, pend_lt_d;
    logic [31:0]       readdata_q, readdata_d;

    logic              busy, wr_ctrl, wr_len, last_word;
    logic [LEN_W-1:0]  len_clamped;
    logic [15:0]       word_base;
    logic              hit_mis, hit_nul, mis_lt;
    logic [1:0]        mis_j, nul_j;
    logic [31:0]       control_rd;
    logic              unused_wd;

    assign busy        = (state_q == S_FETCH) || (state_q == S_CMP);
    assign wr_ctrl     = chipselect && write && (address == REG_CONTROL);
    assign wr_len      = chipselect && write && (address == REG_LENGTH);
    assign len_clamped = (length_q > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : length_q;
    assign last_word   = ({1'b0, w_q} == (run_len_q - LEN_W'(1)));
    assign word_base   = 16'(w_q) << 2;
    assign unused_wd   = ^writedata;

    assign readdata    = readdata_q;
    assign buf_rd_en   = (state_q == S_FETCH);
    assign buf_rd_addr = w_q;

`ifdef STRCMP_IRQ_EN
    logic ie_q, ie_d;
    assign ie_d       = wr_ctrl ? writedata[2] : ie_q;
    assign control_rd = {29'd0, ie_q, 2'b00};
    assign irq        = done_q & ie_q;

    always_ff @(posedge clk) begin
        if (reset) ie_q <= 1'b0;
        else       ie_q <= ie_d;
    end
`else
    assign control_rd = 32'd0;
    assign irq        = 1'b0;
`endif

    // Lowest byte lane wins, so scan from the top and let later hits overwrite.
    always_comb begin
        hit_mis = 1'b0;
        hit_nul = 1'b0;
        mis_j   = 2'd0;
        nul_j   = 2'd0;
        mis_lt  = 1'b0;
        for (int j = 3; j >= 0; j--) begin
            if (bufA_rdata[8*j +: 8] != bufB_rdata[8*j +: 8]) begin
                hit_mis = 1'b1;
                mis_j   = 2'(j);
                mis_lt  = bufA_rdata[8*j +: 8] < bufB_rdata[8*j +: 8];
            end
            if (bufA_rdata[8*j +: 8] == 8'd0 && bufB_rdata[8*j +: 8] == 8'd0) begin
                hit_nul = 1'b1;
                nul_j   = 2'(j);
            end
        end
    end

    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        length_d     = length_q;
        run_len_d    = run_len_q;
        done_d       = done_q;
        equal_d      = equal_q;
        lt_d         = lt_q;
        index_d      = index_q;
        count_d      = count_q;
        pend_index_d = pend_index_q;
        pend_count_d = pend_count_q;
        pend_equal_d = pend_equal_q;
        pend_lt_d    = pend_lt_q;
        readdata_d   = readdata_q;

        if (chipselect && read) begin
            case (address)
                REG_CONTROL: readdata_d = control_rd;
                REG_LENGTH:  readdata_d = 32'(length_q);
                REG_STATUS:  readdata_d = {28'd0, lt_q, equal_q, busy, done_q};
                REG_RESULT:  readdata_d = {count_q, index_q};
                default:     readdata_d = readdata_q;
            endcase
        end

        if (wr_ctrl && writedata[1]) begin
            done_d  = 1'b0;
            equal_d = 1'b0;
            lt_d    = 1'b0;
        end

        if (wr_len && !busy) length_d = writedata[ADDR_W:0];

        case (state_q)
            S_IDLE: begin
                if (wr_ctrl && writedata[0]) begin
                    done_d    = 1'b0;
                    equal_d   = 1'b0;
                    lt_d      = 1'b0;
                    w_d       = '0;
                    run_len_d = len_clamped;
                    if (len_clamped == '0) begin
                        pend_index_d = 16'd0;
                        pend_count_d = 16'd0;
                        pend_equal_d = 1'b1;
                        pend_lt_d    = 1'b0;
                        state_d      = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_CMP;
            S_CMP: begin
                pend_count_d = 16'(w_q) + 16'd1;
                pend_lt_d    = 1'b0;
                pend_equal_d = 1'b1;
                state_d      = S_DONE;
                if (hit_mis) begin
                    pend_index_d = word_base + 16'(mis_j);
                    pend_equal_d = 1'b0;
                    pend_lt_d    = mis_lt;
                end else if (hit_nul) begin
                    pend_index_d = word_base + 16'(nul_j);
                end else if (last_word) begin
                    pend_index_d = 16'(run_len_q) << 2;
                end else begin
                    w_d     = w_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                equal_d = pend_equal_q;
                lt_d    = pend_lt_q;
                index_d = pend_index_q;
                count_d = pend_count_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            w_q          <= '0;
            length_q     <= '0;
            run_len_q    <= '0;
            done_q       <= 1'b0;
            equal_q      <= 1'b0;
            lt_q         <= 1'b0;
            index_q      <= 16'd0;
            count_q      <= 16'd0;
            pend_index_q <= 16'd0;
            pend_count_q <= 16'd0;
            pend_equal_q <= 1'b0;
            pend_lt_q    <= 1'b0;
            readdata_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            length_q     <= length_d;
            run_len_q    <= run_len_d;
            done_q       <= done_d;
            equal_q      <= equal_d;
            lt_q         <= lt_d;
            index_q      <= index_d;
            count_q      <= count_d;
            pend_index_q <= pend_index_d;
            pend_count_q <= pend_count_d;
            pend_equal_q <= pend_equal_d;
            pend_lt_q    <= pend_lt_d;
            readdata_q   <= readdata_d;
        end
    end
endmodule

// File: tb/tb_string_cmp_controller.sv
// Self-checking bench for string_cmp_controller: byte-level string model, per-cycle read-master
// and irq checks, directed cases with literal expectations, then randomized runs.
module tb_string_cmp_controller;
    localparam int MAXW = 8;
    localparam int AW   = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          chipselect = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [1:0]    address = 2'd0;
    logic [31:0]   writedata = 32'd0;
    logic [31:0]   readdata;
    logic          buf_rd_en;
    logic [AW-1:0] buf_rd_addr;
    logic [31:0]   bufA_rdata = 32'd0;
    logic [31:0]   bufB_rdata = 32'd0;
    logic          irq;

    logic [31:0]   mem_a [MAXW];
    logic [31:0]   mem_b [MAXW];

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;

    // Reference model state: when the last accepted run started and what it must produce.
    bit            active = 1'b0;
    int            go_cyc = 0;
    int            run_k = 0;
    int            model_len = 0;
    bit            ie_m = 1'b0;
    bit            done_clr = 1'b0;
    logic [31:0]   exp_status = 32'd0;
    logic [31:0]   exp_result = 32'd0;

    string_cmp_controller #(.MAX_WORDS(MAXW)) dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .read        (read),
        .write       (write),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .bufA_rdata  (bufA_rdata),
        .bufB_rdata  (bufB_rdata),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous buffer model: data valid the cycle after the read enable.
    always @(posedge clk) begin
        if (buf_rd_en) begin
            bufA_rdata <= mem_a[buf_rd_addr];
            bufB_rdata <= mem_b[buf_rd_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Strings compared word by word; inside a word any mismatch outranks a shared terminator.
    function automatic void model_run(input int len, output int k,
                                      output logic [31:0] status, output logic [31:0] result);
        int         l, idx;
        bit         eq, lt, stop;
        logic [7:0] a, b;
        l    = (len > MAXW) ? MAXW : len;
        k    = l;
        idx  = 4 * l;
        eq   = 1'b1;
        lt   = 1'b0;
        stop = 1'b0;
        for (int w = 0; w < l && !stop; w++) begin
            for (int j = 0; j < 4 && !stop; j++) begin
                a = mem_a[w][8*j +: 8];
                b = mem_b[w][8*j +: 8];
                if (a != b) begin
                    idx = 4 * w + j; eq = 1'b0; lt = (a < b); k = w + 1; stop = 1'b1;
                end
            end
            for (int j = 0; j < 4 && !stop; j++) begin
                if (mem_a[w][8*j +: 8] == 8'd0) begin
                    idx = 4 * w + j; k = w + 1; stop = 1'b1;
                end
            end
        end
        status = {28'd0, lt, eq, 1'b0, 1'b1};
        result = {16'(k), 16'(idx)};
    endfunction

    // A run accepted at edge go_cyc fetches on even offsets 0..2k-2 and sets done at offset 2k+1.
    always begin
        @(posedge clk);
        #2;
        begin : cmp_blk
            int n;
            bit exp_en, exp_irq;
            n      = cyc - go_cyc;
            exp_en = active && n >= 0 && n < 2 * run_k && (n % 2) == 0;
            check("buf_rd_en", 32'(buf_rd_en), 32'(exp_en));
            if (exp_en) check("buf_rd_addr", 32'(buf_rd_addr), 32'(n / 2));
`ifdef STRCMP_IRQ_EN
            exp_irq = ie_m && active && n >= 2 * run_k + 1 && !done_clr;
`else
            exp_irq = 1'b0;
`endif
            check("irq", 32'(irq), 32'(exp_irq));
        end
    end

    task automatic avl_write(input logic [1:0] a, input logic [31:0] d);
        int n;
        n = cyc - go_cyc;
        if (a == 2'd1 && (!active || n >= 2 * run_k)) model_len = int'(d[AW:0]);
        if (a == 2'd0) begin
`ifdef STRCMP_IRQ_EN
            ie_m = d[2];
`endif
            if (d[1]) done_clr = 1'b1;
            if (d[0] && (!active || n >= 2 * run_k + 1)) begin
                model_run(model_len, run_k, exp_status, exp_result);
                go_cyc   = cyc + 1;
                active   = 1'b1;
                done_clr = 1'b0;
            end
        end
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic avl_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    // GO, then STATUS sampled at offsets 1, 2k+1 (pre-update) and 2k+2 (final), then RESULT.
    task automatic timed_run(input string tag);
        logic [31:0] d;
        int          k;
        avl_write(2'd0, {29'd0, ie_m, 2'b01});
        k = run_k;
        if (k > 0) begin
            avl_read(2'd2, d);
            check({tag, "_busy"}, d, 32'h2);
            repeat (2 * k - 1) @(negedge clk);
            avl_read(2'd2, d);
            check({tag, "_pre_done"}, d, 32'h0);
        end else begin
            avl_read(2'd2, d);
            check({tag, "_pre_done_busy"}, 32'(d[1:0]), 32'h0);
        end
        avl_read(2'd2, d);
        check({tag, "_status"}, d, exp_status);
        avl_read(2'd3, d);
        check({tag, "_result"}, d, exp_result);
    endtask

    task automatic fill_nonnull();
        for (int w = 0; w < MAXW; w++) begin
            mem_a[w] = $urandom | 32'h0101_0101;
            mem_b[w] = mem_a[w];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        bit          got;
        fill_nonnull();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_readdata", readdata, 32'h0);
        check("rst_buf_rd_addr", 32'(buf_rd_addr), 32'h0);
        avl_read(2'd2, d); check("rst_status", d, 32'h0);
        avl_read(2'd3, d); check("rst_result", d, 32'h0);
        avl_read(2'd1, d); check("rst_length", d, 32'h0);
        avl_read(2'd0, d); check("rst_control", d, 32'h0);

        // "abcd" + "efg\0" on both sides: equal, terminator at byte 7.
        mem_a[0] = 32'h6463_6261; mem_a[1] = 32'h0067_6665;
        mem_b[0] = 32'h6463_6261; mem_b[1] = 32'h0067_6665;
        avl_write(2'd1, 32'd2);
        timed_run("t1");
        avl_read(2'd2, d); check("t1_status_lit", d, 32'h5);
        avl_read(2'd3, d); check("t1_result_lit", d, 32'h0002_0007);
        avl_read(2'd1, d); check("t1_length_rb", d, 32'd2);

        // 'b' < 'j' at byte 1.
        mem_a[0] = 32'h6463_6261; mem_b[0] = 32'h6463_6A61;
        avl_write(2'd1, 32'd1);
        timed_run("t2");
        avl_read(2'd2, d); check("t2_status_lit", d, 32'h9);
        avl_read(2'd3, d); check("t2_result_lit", d, 32'h0001_0001);

        avl_write(2'd1, 32'd0);
        timed_run("t3");
        avl_read(2'd2, d); check("t3_status_lit", d, 32'h5);
        avl_read(2'd3, d); check("t3_result_lit", d, 32'h0);

        // LENGTH above MAX_WORDS clamps to a full-buffer compare.
        fill_nonnull();
        avl_write(2'd1, 32'd12);
        timed_run("t4");
        avl_read(2'd2, d); check("t4_status_lit", d, 32'h5);
        avl_read(2'd3, d); check("t4_result_lit", d, 32'h0008_0020);

        // IE write (ignored without the interrupt option), then CLR keeps RESULT.
        avl_write(2'd0, 32'h4);
        repeat (2) @(negedge clk);
        avl_read(2'd0, d); check("ctrl_ie_rb", d, {29'd0, ie_m, 2'b00});
        avl_write(2'd0, 32'h6);
        avl_read(2'd2, d); check("clr_status", d, 32'h0);
        avl_read(2'd3, d); check("clr_result", d, 32'h0008_0020);

        // GO and LENGTH while busy must not disturb the run.
        fill_nonnull();
        avl_write(2'd1, 32'd5);
        avl_write(2'd0, {29'd0, ie_m, 2'b01});
        avl_write(2'd1, 32'd2);
        avl_write(2'd0, {29'd0, ie_m, 2'b01});
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            avl_read(2'd2, d);
            if (d[0]) got = 1'b1;
        end
        check("mid_done_seen", 32'(got), 32'h1);
        avl_read(2'd2, d); check("mid_status", d, exp_status);
        avl_read(2'd3, d); check("mid_result_lit", d, 32'h0005_0014);
        avl_read(2'd1, d); check("mid_length", d, 32'd5);

        // Reset sampled while the second fetch is presented.
        fill_nonnull();
        avl_write(2'd1, 32'd4);
        avl_write(2'd0, {29'd0, ie_m, 2'b01});
        repeat (2) @(negedge clk);
        reset = 1'b1; active = 1'b0; model_len = 0; ie_m = 1'b0; done_clr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        avl_read(2'd2, d); check("mrst_status", d, 32'h0);
        avl_read(2'd3, d); check("mrst_result", d, 32'h0);
        avl_read(2'd1, d); check("mrst_length", d, 32'h0);

        for (int r = 0; r < 40; r++) begin
            int mode, wi, ji, j2;
            mode = $urandom_range(0, 3);
            wi   = $urandom_range(0, MAXW - 1);
            ji   = $urandom_range(0, 3);
            j2   = $urandom_range(0, 3);
            fill_nonnull();
            if (mode == 1 || mode == 3) begin
                mem_a[wi][8*ji +: 8] = 8'h00;
                mem_b[wi][8*ji +: 8] = 8'h00;
            end
            if (mode == 2 || mode == 3)
                mem_b[wi][8*j2 +: 8] = mem_b[wi][8*j2 +: 8] ^ 8'($urandom_range(1, 255));
            avl_write(2'd1, 32'($urandom_range(0, 15)));
            timed_run($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
